// File: rtl/antares_load_store_unit_if.sv
// -----------------------------------------------------------------------------
// antares_load_store_unit_if
//
// Data-port bus between the load/store unit (master) and the data memory or
// bus fabric (slave). Single outstanding request/ready transaction.
//
// Signals:
//   dport_address  30  word address (byte address [31:2])
//   dport_data_o   32  lane-aligned write data, master -> slave
//   dport_wr        4  byte write enables, [3] = bits 31:24; 0000 for reads
//   dport_enable    1  transaction valid, held until ready/error/timeout
//   dport_data_i   32  read data, slave -> master
//   dport_ready     1  transaction complete (single-cycle pulse)
//   dport_error     1  slave error, valid with or without ready
// -----------------------------------------------------------------------------
interface antares_load_store_unit_if;
   logic [29:0] dport_address;
   logic [31:0] dport_data_o;
   logic [3:0]  dport_wr;
   logic        dport_enable;
   logic [31:0] dport_data_i;
   logic        dport_ready;
   logic        dport_error;

   modport master (
      output dport_address,
      output dport_data_o,
      output dport_wr,
      output dport_enable,
      input  dport_data_i,
      input  dport_ready,
      input  dport_error
   );

   modport slave (
      input  dport_address,
      input  dport_data_o,
      input  dport_wr,
      input  dport_enable,
      output dport_data_i,
      output dport_ready,
      output dport_error
   );
endinterface

// File: rtl/antares_load_store_unit.sv
// -----------------------------------------------------------------------------
// antares_load_store_unit
//
// Memory-stage data-port controller. Takes the effective address and store
// data from EX plus the decoded load/store controls, runs one request/ready
// transaction on the data port while stalling the pipeline, aligns store data
// into big-endian byte lanes, extracts/extends load data and raises
// address-error and bus-error exceptions.
//
// Parameters:
//   BUS_TIMEOUT              WAIT cycles without ready before a bus error (1-255)
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   mem_address              effective address (EX ALU result)
//   mem_store_data           store data, LSBs significant for byte/half
//   mem_mem_read/_write      load / store in MEM
//   mem_byte, mem_halfword   access size (byte wins); neither = word
//   mem_sign_extend          sign-extend loaded byte/half
//   mem_stall                global stall (includes our own request)
//   mem_flush                kill the instruction in MEM
//   mem_request_stall        stall request to the hazard unit
//   mem_read_data            formatted, registered load data
//   exc_address_error_load   misaligned load (combinational)
//   exc_address_error_store  misaligned store (combinational)
//   exc_bus_error            bus error or timeout on the current access
//   dport                    data-port bus, master side
// -----------------------------------------------------------------------------
module antares_load_store_unit #(
   parameter logic [7:0] BUS_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_data,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        mem_byte,
   input  logic        mem_halfword,
   input  logic        mem_sign_extend,
   input  logic        mem_stall,
   input  logic        mem_flush,
   output logic        mem_request_stall,
   output logic [31:0] mem_read_data,
   output logic        exc_address_error_load,
   output logic        exc_address_error_store,
   output logic        exc_bus_error,
   antares_load_store_unit_if.master dport
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_count;
   logic        r_flushed;
   logic [29:0] r_address;
   logic [31:0] r_data_o;
   logic [3:0]  r_wr;
   logic [31:0] r_read_data;
   logic        r_bus_error;

   // Load controls captured at start so formatting does not depend on the
   // MEM-stage inputs staying put during WAIT.
   logic        r_is_load;
   logic        r_byte;
   logic        r_half;
   logic        r_sext;
   logic [1:0]  r_lane;

   logic        w_idle;
   logic        w_wait;
   logic        w_done;
   logic        w_access;
   logic        w_word;
   logic        w_misaligned;
   logic        w_start;
   logic        w_ext_stall;
   logic [7:0]  w_count_inc;
   logic        w_timeout;
   logic        w_end;
   logic        w_killed;
   logic        w_good_ready;
   logic [31:0] w_store_data;
   logic [3:0]  w_store_wr;
   logic [7:0]  w_lane_byte;
   logic [15:0] w_lane_half;
   logic [31:0] w_load_data;

   // ---------------------------------------------------------------------------
   // Decode, alignment and start
   // ---------------------------------------------------------------------------
   assign w_idle       = (r_state == StIdle);
   assign w_wait       = (r_state == StWait);
   assign w_done       = (r_state == StDone);
   assign w_access     = mem_mem_read | mem_mem_write;
   assign w_word       = ~mem_byte & ~mem_halfword;
   assign w_misaligned = (~mem_byte & mem_halfword & mem_address[0]) |
                         (w_word & (mem_address[1:0] != 2'b00));
   assign w_start      = w_access & ~w_misaligned & ~mem_flush & w_idle;

   assign exc_address_error_load  = mem_mem_read & w_misaligned & w_idle & ~mem_flush;
   assign exc_address_error_store = mem_mem_write & w_misaligned & w_idle & ~mem_flush;

   // Never derived from mem_stall, which already contains this request.
   assign mem_request_stall = w_start | w_wait;

   // Stall coming from elsewhere in the pipeline; only meaningful in DONE.
   assign w_ext_stall = mem_stall & ~mem_request_stall;

   // ---------------------------------------------------------------------------
   // WAIT bookkeeping
   // ---------------------------------------------------------------------------
   // r_count holds completed WAIT cycles, so w_count_inc counts the current one
   // and the bus error fires on exactly the BUS_TIMEOUT-th WAIT cycle.
   assign w_count_inc  = r_count + 8'd1;
   assign w_timeout    = (w_count_inc == BUS_TIMEOUT);
   assign w_end        = dport.dport_ready | dport.dport_error | w_timeout;
   assign w_killed     = r_flushed | mem_flush;
   assign w_good_ready = dport.dport_ready & ~dport.dport_error;

   // ---------------------------------------------------------------------------
   // Store formatting (big-endian: addr[1:0] = 0 is bits 31:24)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_store_data = mem_store_data;
      w_store_wr   = 4'b1111;
      if (mem_byte) begin
         w_store_data = {4{mem_store_data[7:0]}};
         w_store_wr   = 4'b1000 >> mem_address[1:0];
      end else if (mem_halfword) begin
         w_store_data = {2{mem_store_data[15:0]}};
         w_store_wr   = mem_address[1] ? 4'b0011 : 4'b1100;
      end
   end

   // ---------------------------------------------------------------------------
   // Load formatting
   // ---------------------------------------------------------------------------
   always_comb begin
      w_lane_byte = dport.dport_data_i[31:24];
      unique case (r_lane)
         2'd0:    w_lane_byte = dport.dport_data_i[31:24];
         2'd1:    w_lane_byte = dport.dport_data_i[23:16];
         2'd2:    w_lane_byte = dport.dport_data_i[15:8];
         2'd3:    w_lane_byte = dport.dport_data_i[7:0];
         default: w_lane_byte = dport.dport_data_i[31:24];
      endcase
      w_lane_half = r_lane[1] ? dport.dport_data_i[15:0] : dport.dport_data_i[31:16];

      if (r_byte) begin
         w_load_data = {{24{r_sext & w_lane_byte[7]}}, w_lane_byte};
      end else if (r_half) begin
         w_load_data = {{16{r_sext & w_lane_half[15]}}, w_lane_half};
      end else begin
         w_load_data = dport.dport_data_i;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_next = StWait;
            end
         end
         StWait: begin
            // A flushed access still runs to completion on the bus, but there
            // is no one left to consume its result.
            if (w_end) begin
               w_state_next = w_killed ? StIdle : StDone;
            end
         end
         StDone: begin
            if (mem_flush || !w_ext_stall) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= 8'd0;
         r_flushed   <= 1'b0;
         r_address   <= 30'd0;
         r_data_o    <= 32'd0;
         r_wr        <= 4'd0;
         r_read_data <= 32'd0;
         r_bus_error <= 1'b0;
         r_is_load   <= 1'b0;
         r_byte      <= 1'b0;
         r_half      <= 1'b0;
         r_sext      <= 1'b0;
         r_lane      <= 2'd0;
      end else begin
         if (w_start) begin
            r_address <= mem_address[31:2];
            r_data_o  <= w_store_data;
            r_wr      <= mem_mem_write ? w_store_wr : 4'b0000;
            r_count   <= 8'd0;
            r_flushed <= 1'b0;
            r_is_load <= mem_mem_read & ~mem_mem_write;
            r_byte    <= mem_byte;
            r_half    <= ~mem_byte & mem_halfword;
            r_sext    <= mem_sign_extend;
            r_lane    <= mem_address[1:0];
         end

         if (w_wait) begin
            r_count <= w_count_inc;
            if (mem_flush) begin
               r_flushed <= 1'b1;
            end
            if (w_end) begin
               r_flushed <= 1'b0;
               if (!w_killed) begin
                  // A clean ready wins over a timeout landing on the same cycle.
                  if (w_good_ready) begin
                     if (r_is_load) begin
                        r_read_data <= w_load_data;
                     end
                  end else begin
                     r_bus_error <= 1'b1;
                     r_read_data <= 32'd0;
                  end
               end
            end
         end

         if (w_done && (w_state_next == StIdle)) begin
            r_bus_error <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign mem_read_data       = r_read_data;
   assign exc_bus_error       = r_bus_error;
   assign dport.dport_address = r_address;
   assign dport.dport_data_o  = r_data_o;
   assign dport.dport_wr      = r_wr;
   assign dport.dport_enable  = w_wait;

endmodule

// File: tb/tb_antares_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_antares_load_store_unit
//
// Directed vectors with hand-computed expectations. The driver pushes the
// expected bus request, completion result and address-error events into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// A responder process models the data-port slave.
// -----------------------------------------------------------------------------
module tb_antares_load_store_unit;

   logic        clk;
   logic        rst;
   logic [31:0] mem_address;
   logic [31:0] mem_store_data;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic        mem_byte;
   logic        mem_halfword;
   logic        mem_sign_extend;
   logic        mem_stall;
   logic        mem_flush;
   logic        mem_request_stall;
   logic [31:0] mem_read_data;
   logic        exc_address_error_load;
   logic        exc_address_error_store;
   logic        exc_bus_error;
   logic        ext_stall;

   antares_load_store_unit_if dport_bus ();

   antares_load_store_unit #(
      .BUS_TIMEOUT (8'd255)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .mem_address             (mem_address),
      .mem_store_data          (mem_store_data),
      .mem_mem_read            (mem_mem_read),
      .mem_mem_write           (mem_mem_write),
      .mem_byte                (mem_byte),
      .mem_halfword            (mem_halfword),
      .mem_sign_extend         (mem_sign_extend),
      .mem_stall               (mem_stall),
      .mem_flush               (mem_flush),
      .mem_request_stall       (mem_request_stall),
      .mem_read_data           (mem_read_data),
      .exc_address_error_load  (exc_address_error_load),
      .exc_address_error_store (exc_address_error_store),
      .exc_bus_error           (exc_bus_error),
      .dport                   (dport_bus)
   );

   // Global stall as the hazard unit would form it.
   assign mem_stall = mem_request_stall | ext_stall;

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  wr;
      logic [31:0] data;
   } bus_t;

   typedef struct {
      logic [31:0] rd;
      logic        berr;
      int          stall;
      int          en;
   } done_t;

   typedef struct packed {
      bit          rd;
      bit          wr;
      bit          bt;
      bit          hw;
      bit          sx;
      logic [31:0] addr;
      logic [31:0] sdata;
      int          delay;      // WAIT cycle carrying ready; 0 = never
      bit          err;
      logic [31:0] idata;
      int          flush_at;   // cycle after issue carrying mem_flush; 0 = none
      int          done_stall; // external stall cycles held in DONE
      bit          ael;
      bit          aes;
      logic [29:0] waddr;
      logic [3:0]  wr_en;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          berr;
      int          stall;
      int          en;
   } vec_t;

   bus_t       q_bus[$];
   done_t      q_done[$];
   logic [1:0] q_aerr[$];
   vec_t       vecs[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   int          rsp_delay = 0;
   bit          rsp_error = 1'b0;
   logic [31:0] rsp_data  = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Data-port slave: ready (optionally with error) on the rsp_delay-th
   // cycle of enable.
   initial begin
      int cnt;
      cnt = 0;
      dport_bus.dport_ready  = 1'b0;
      dport_bus.dport_error  = 1'b0;
      dport_bus.dport_data_i = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         dport_bus.dport_ready  = 1'b0;
         dport_bus.dport_error  = 1'b0;
         dport_bus.dport_data_i = rsp_data;
         if (dport_bus.dport_enable) begin
            cnt++;
            if (rsp_delay != 0 && cnt == rsp_delay) begin
               dport_bus.dport_ready = 1'b1;
               dport_bus.dport_error = rsp_error;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor
   initial begin
      bit    prev_en;
      bit    prev_stall;
      int    stall_cnt;
      int    en_cnt;
      int    unstable;
      bus_t  cap;
      bus_t  eb;
      done_t ed;
      logic [1:0] ea;
      prev_en    = 1'b0;
      prev_stall = 1'b0;
      stall_cnt  = 0;
      en_cnt     = 0;
      unstable   = 0;
      cap        = '{30'd0, 4'd0, 32'd0};
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (dport_bus.dport_enable && !prev_en) begin
               cap = '{dport_bus.dport_address, dport_bus.dport_wr, dport_bus.dport_data_o};
               unstable = 0;
               if (q_bus.size() == 0) begin
                  check("unexpected_bus_request", 32'(dport_bus.dport_address), 32'hFFFFFFFF);
               end else begin
                  eb = q_bus.pop_front();
                  check("dport_address", 32'(dport_bus.dport_address), 32'(eb.addr));
                  check("dport_wr", 32'(dport_bus.dport_wr), 32'(eb.wr));
                  check("dport_data_o", dport_bus.dport_data_o, eb.data);
               end
            end else if (dport_bus.dport_enable) begin
               if (dport_bus.dport_address != cap.addr || dport_bus.dport_wr != cap.wr ||
                   dport_bus.dport_data_o != cap.data) begin
                  unstable++;
               end
            end else if (prev_en) begin
               check("dport_stable", 32'(unstable), 32'd0);
            end

            if (exc_address_error_load || exc_address_error_store) begin
               if (q_aerr.size() == 0) begin
                  check("unexpected_address_error",
                        32'({exc_address_error_load, exc_address_error_store}), 32'd0);
               end else begin
                  ea = q_aerr.pop_front();
                  check("address_error_ls",
                        32'({exc_address_error_load, exc_address_error_store}), 32'(ea));
               end
            end

            if (mem_request_stall) stall_cnt++;
            if (dport_bus.dport_enable) en_cnt++;
            if (prev_stall && !mem_request_stall) begin
               if (q_done.size() == 0) begin
                  check("unexpected_completion", 32'(stall_cnt), 32'd0);
               end else begin
                  ed = q_done.pop_front();
                  check("mem_read_data", mem_read_data, ed.rd);
                  check("exc_bus_error", 32'(exc_bus_error), 32'(ed.berr));
                  check("stall_cycles", 32'(stall_cnt), 32'(ed.stall));
                  check("enable_cycles", 32'(en_cnt), 32'(ed.en));
               end
               stall_cnt = 0;
               en_cnt    = 0;
            end
         end
         prev_en    = dport_bus.dport_enable;
         prev_stall = mem_request_stall;
      end
   end

   task automatic drive(input vec_t v);
      mem_address     = v.addr;
      mem_store_data  = v.sdata;
      mem_mem_read    = v.rd;
      mem_mem_write   = v.wr;
      mem_byte        = v.bt;
      mem_halfword    = v.hw;
      mem_sign_extend = v.sx;
   endtask

   task automatic clear_req();
      mem_mem_read  = 1'b0;
      mem_mem_write = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int cyc;
      if (v.ael || v.aes) begin
         q_aerr.push_back({v.ael, v.aes});
         drive(v);
         #1;
         check("aerr_no_stall", 32'(mem_request_stall), 32'd0);
         @(posedge clk); #1;
         clear_req();
         @(posedge clk); #1;
         return;
      end
      if (!v.rd && !v.wr) begin
         drive(v);
         #1;
         check("nonmem_no_stall", 32'(mem_request_stall), 32'd0);
         @(posedge clk); #1;
         check("nonmem_no_enable", 32'(dport_bus.dport_enable), 32'd0);
         return;
      end
      q_bus.push_back('{v.waddr, v.wr_en, v.wdata});
      q_done.push_back('{v.exp_rd, v.berr, v.stall, v.en});
      rsp_delay = v.delay;
      rsp_error = v.err;
      rsp_data  = v.idata;
      drive(v);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == v.flush_at) begin
            mem_flush = 1'b1;
            clear_req();
         end else begin
            mem_flush = 1'b0;
         end
      end while (mem_request_stall && cyc < 400);
      mem_flush = 1'b0;
      check("txn_ends_in_budget", 32'(mem_request_stall), 32'd0);
      if (v.done_stall > 0) begin
         ext_stall = 1'b1;
         repeat (v.done_stall) begin
            @(posedge clk); #1;
            check("done_hold_read_data", mem_read_data, v.exp_rd);
         end
         ext_stall = 1'b0;
      end
      clear_req();
      @(posedge clk); #1;
      check("idle_bus_error_clear", 32'(exc_bus_error), 32'd0);
      check("idle_no_stall", 32'(mem_request_stall), 32'd0);
   endtask

   initial begin
      // rd wr bt hw sx addr sdata delay err idata flush_at done_stall
      //   ael aes waddr wr_en wdata exp_rd berr stall en
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 4, 3});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h103, 32'h000000A5, 1, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'h1, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 2, 1'b0, 32'h000000F0, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'h0, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 2});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 1, 1'b0, 32'h000000F0, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'h0, 32'h0, 32'h000000F0, 1'b0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 1, 1'b0, 32'h12348001, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2, 1'b0, 32'h12348001, 0, 0,
                       1'b0, 1'b0, 30'h40, 4'h0, 32'h0, 32'h00001234, 1'b0, 3, 2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1, 1'b0, 32'hCAFEF00D, 0, 0,
                       1'b0, 1'b0, 30'h80, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h202, 32'h1234BEEF, 2, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'h80, 4'h3, 32'hBEEFBEEF, 32'hCAFEF00D, 1'b0, 3, 2});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h201, 32'h0000005A, 1, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'h80, 4'h4, 32'h5A5A5A5A, 32'hCAFEF00D, 1'b0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0, 0, 1'b0, 32'h0, 0, 0,
                       1'b1, 1'b0, 30'h0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0, 0, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 2, 1'b1, 32'hFFFFFFFF, 0, 0,
                       1'b0, 1'b0, 30'h81, 4'h0, 32'h0, 32'h0, 1'b1, 3, 2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1, 1'b0, 32'h11223344, 0, 0,
                       1'b0, 1'b0, 30'hC0, 4'h0, 32'h0, 32'h11223344, 1'b0, 2, 1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 4, 1'b0, 32'h55667788, 2, 0,
                       1'b0, 1'b0, 30'h41, 4'h0, 32'h0, 32'h11223344, 1'b0, 5, 4});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h308, 32'h0, 0, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'hC2, 4'h0, 32'h0, 32'h0, 1'b1, 256, 255});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 1, 1'b0, 32'h80010000, 0, 5,
                       1'b0, 1'b0, 30'h40, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 2, 1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h103, 32'h0, 0, 1'b0, 32'h0, 0, 0,
                       1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0});

      rst             = 1'b1;
      ext_stall       = 1'b0;
      mem_flush       = 1'b0;
      mem_address     = 32'd0;
      mem_store_data  = 32'd0;
      mem_byte        = 1'b0;
      mem_halfword    = 1'b0;
      mem_sign_extend = 1'b0;
      clear_req();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_enable", 32'(dport_bus.dport_enable), 32'd0);
      check("reset_wr", 32'(dport_bus.dport_wr), 32'd0);
      check("reset_address", 32'(dport_bus.dport_address), 32'd0);
      check("reset_data_o", dport_bus.dport_data_o, 32'd0);
      check("reset_read_data", mem_read_data, 32'd0);
      check("reset_bus_error", 32'(exc_bus_error), 32'd0);
      check("reset_stall", 32'(mem_request_stall), 32'd0);
      mon_en = 1'b1;

      foreach (vecs[i]) run(vecs[i]);

      // Reset while waiting on a slave that never answers.
      q_bus.push_back('{30'h100, 4'h0, 32'h0});
      q_done.push_back('{32'h0, 1'b0, 4, 3});
      rsp_delay       = 0;
      rsp_error       = 1'b0;
      mem_address     = 32'h400;
      mem_store_data  = 32'h0;
      mem_byte        = 1'b0;
      mem_halfword    = 1'b0;
      mem_sign_extend = 1'b0;
      mem_mem_read    = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      clear_req();
      @(posedge clk); #1;
      rst = 1'b0;
      check("midwait_rst_enable", 32'(dport_bus.dport_enable), 32'd0);
      check("midwait_rst_wr", 32'(dport_bus.dport_wr), 32'd0);
      check("midwait_rst_address", 32'(dport_bus.dport_address), 32'd0);
      check("midwait_rst_data_o", dport_bus.dport_data_o, 32'd0);
      check("midwait_rst_read_data", mem_read_data, 32'd0);
      check("midwait_rst_bus_error", 32'(exc_bus_error), 32'd0);
      check("midwait_rst_stall", 32'(mem_request_stall), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      check("q_bus_drained", 32'(q_bus.size()), 32'd0);
      check("q_done_drained", 32'(q_done.size()), 32'd0);
      check("q_aerr_drained", 32'(q_aerr.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
